// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory arbiter: controller states and the tag that
// follows a read from acceptance to its response strobe.
package mem_ctrl_pkg;
  localparam int MAX_REQ   = 8;
  localparam int REQ_IDX_W = $clog2(MAX_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] idx;
  } rsp_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest request at or above the pointer
// wins; if there is none, the lowest request overall wins (wrap-around).
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant
);
  logic [NUM_REQ-1:0] ptr_onehot;
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick_from;

  assign ptr_onehot = NUM_REQ'(1) << ptr;
  assign upper_mask = ~(ptr_onehot - NUM_REQ'(1));
  assign upper_req  = req & upper_mask;
  assign pick_from  = (|upper_req) ? upper_req : req;
  // x & -x isolates the lowest set bit
  assign grant      = pick_from & (~pick_from + NUM_REQ'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for a single-port, registered-read memory, with a
// built-in sweep that fills every address with CLEAR_VALUE on request.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_REQ     = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic                          clear_start,
  output logic                          busy,
  output logic                          clear_done,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);
  arb_state_e            state;
  logic [REQ_IDX_W-1:0]  rr_ptr;
  logic [REQ_IDX_W-1:0]  grant_idx;
  logic [REQ_IDX_W-1:0]  next_ptr;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  accept;
  rsp_tag_t              cmd_tag;
  rsp_tag_t              rsp_tag;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(arb_grant)
  );

  assign req_ready = (!reset && state == IDLE && !clear_start) ? arb_grant : '0;
  assign accept    = |req_ready;
  assign next_ptr  = (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + REQ_IDX_W'(1);
  assign rsp_rdata = mem_rdata;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        grant_idx = REQ_IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = req_we[i];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rsp_tag.valid && (rsp_tag.idx == REQ_IDX_W'(i));
    end
  end

  // The tag pair tracks memory latency: cmd_tag rides alongside mem_*, rsp_tag
  // lines up with the registered read data, so reads already issued still
  // answer while the sweep owns the memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      cmd_tag    <= '0;
      rsp_tag    <= '0;
    end else begin
      clear_done <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      cmd_tag    <= '0;
      rsp_tag    <= cmd_tag;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end else if (accept) begin
            mem_addr      <= sel_addr;
            mem_wdata     <= sel_wdata;
            mem_wr_en     <= sel_we;
            mem_rd_en     <= !sel_we;
            cmd_tag.valid <= !sel_we;
            cmd_tag.idx   <= grant_idx;
            rr_ptr        <= next_ptr;
          end
        end
        CLEAR: begin
          mem_addr  <= clr_cnt;
          mem_wdata <= CLEAR_VALUE;
          mem_wr_en <= 1'b1;
          clr_cnt   <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == '1) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a registered-read memory, a queue-based
// reference model checked every cycle, directed scenarios and a random phase.
module tb_mem_arbiter;
  localparam int         NR          = 2;
  localparam int         AW          = 8;
  localparam int         DW          = 8;
  localparam int         DEPTH       = 1 << AW;
  localparam logic [7:0] CLEAR_VALUE = 8'h00;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [DW-1:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic               clear_start, busy, clear_done, mem_wr_en, mem_rd_en;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .CLEAR_VALUE(CLEAR_VALUE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .clear_start(clear_start),
    .busy       (busy),
    .clear_done (clear_done),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: single port, one-cycle registered read, powered up to FF.
  logic [DW-1:0] memArr [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) memArr[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= memArr[mem_addr];
  end

  int compareCount = 0;
  int failCount    = 0;
  int doneCount    = 0;
  bit checkEn      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: contents as they must be after every accepted command in
  // order, the expected memory command for the current cycle, and a queue of
  // read responses stamped with the cycle in which they are due.
  typedef struct {
    int         due;
    int         idx;
    logic [7:0] data;
  } rsp_t;

  logic [DW-1:0] refMem [DEPTH];
  rsp_t          rspQ[$];
  int            cycleNo   = 0;
  int            mPtr      = 0;
  bit            mClearing = 1'b0;
  int            mClrCnt   = 0;
  bit            mDoneNow  = 1'b0;
  bit            mCmdWr    = 1'b0;
  bit            mCmdRd    = 1'b0;
  logic [7:0]    mCmdAddr  = '0;
  logic [7:0]    mCmdData  = '0;
  logic [NR-1:0] expReady, expRsp;
  int            gIdx;
  logic [7:0]    gAddr, gData;

  function automatic int modelPick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      memArr[i] = 8'hFF;
      refMem[i] = 8'hFF;
    end
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (clear_done === 1'b1) doneCount++;
  end

  always @(negedge clk) begin
    if (checkEn) begin
      expReady = '0;
      gIdx     = -1;
      if (!reset && !mClearing && !clear_start) begin
        gIdx = modelPick(req_valid, mPtr);
        if (gIdx >= 0) expReady[gIdx] = 1'b1;
      end
      checkOutput("modelReady", 32'(req_ready), 32'(expReady));
      checkOutput("modelBusy", 32'(busy), 32'(mClearing));
      checkOutput("modelClearDone", 32'(clear_done), 32'(mDoneNow));
      checkOutput("modelMemWr", 32'(mem_wr_en), 32'(mCmdWr));
      checkOutput("modelMemRd", 32'(mem_rd_en), 32'(mCmdRd));
      if (mCmdWr || mCmdRd) checkOutput("modelMemAddr", 32'(mem_addr), 32'(mCmdAddr));
      if (mCmdWr) checkOutput("modelMemWdata", 32'(mem_wdata), 32'(mCmdData));
      expRsp = '0;
      if (rspQ.size() > 0 && rspQ[0].due == cycleNo) begin
        expRsp[rspQ[0].idx] = 1'b1;
        checkOutput("modelRspData", 32'(rsp_rdata), 32'(rspQ[0].data));
        void'(rspQ.pop_front());
      end
      checkOutput("modelRspValid", 32'(rsp_valid), 32'(expRsp));

      if (reset) begin
        rspQ.delete();
        mPtr      = 0;
        mClearing = 1'b0;
        mClrCnt   = 0;
        mDoneNow  = 1'b0;
        mCmdWr    = 1'b0;
        mCmdRd    = 1'b0;
      end else begin
        mDoneNow = 1'b0;
        mCmdWr   = 1'b0;
        mCmdRd   = 1'b0;
        if (mClearing) begin
          mCmdWr          = 1'b1;
          mCmdAddr        = 8'(mClrCnt);
          mCmdData        = CLEAR_VALUE;
          refMem[mClrCnt] = CLEAR_VALUE;
          if (mClrCnt == DEPTH - 1) begin
            mClearing = 1'b0;
            mDoneNow  = 1'b1;
          end
          mClrCnt++;
        end else if (clear_start) begin
          mClearing = 1'b1;
          mClrCnt   = 0;
        end else if (gIdx >= 0) begin
          gAddr    = req_addr[gIdx*AW +: AW];
          gData    = req_wdata[gIdx*DW +: DW];
          mCmdAddr = gAddr;
          if (req_we[gIdx]) begin
            mCmdWr        = 1'b1;
            mCmdData      = gData;
            refMem[gAddr] = gData;
          end else begin
            mCmdRd = 1'b1;
            rspQ.push_back('{due: cycleNo + 2, idx: gIdx, data: refMem[gAddr]});
          end
          mPtr = (gIdx + 1) % NR;
        end
      end
      cycleNo++;
    end
  end

  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] we,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1, input logic cs);
    req_valid   = v;
    req_we      = we;
    req_addr    = {a1, a0};
    req_wdata   = {d1, d0};
    clear_start = cs;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
    #2;
  endtask

  int bad, doneBefore;
  bit hit;

  initial begin
    reset = 1'b1;
    applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    repeat (2) nextCycle();
    checkEn = 1'b1;
    midCycle();
    checkOutput("rstReady", 32'(req_ready), 0);
    checkOutput("rstMemWr", 32'(mem_wr_en), 0);
    checkOutput("rstMemRd", 32'(mem_rd_en), 0);
    checkOutput("rstMemAddr", 32'(mem_addr), 0);
    checkOutput("rstMemWdata", 32'(mem_wdata), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(clear_done), 0);
    checkOutput("rstRsp", 32'(rsp_valid), 0);

    // Single read of an untouched address returns the power-up value two cycles later.
    nextCycle(); reset = 1'b0;
    applyStimulus(2'b01, 2'b00, 8'h10, 0, 0, 0, 1'b0);
    midCycle(); checkOutput("t1Ready", 32'(req_ready), 32'h1);
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    midCycle(); checkOutput("t1MemRd", 32'(mem_rd_en), 1); checkOutput("t1MemAddr", 32'(mem_addr), 32'h10);
    checkOutput("t1EarlyRsp", 32'(rsp_valid), 0);
    nextCycle(); midCycle();
    checkOutput("t1RspValid", 32'(rsp_valid), 32'h1); checkOutput("t1RspData", 32'(rsp_rdata), 32'hFF);

    // Write then immediately read back through requester 1.
    nextCycle(); applyStimulus(2'b10, 2'b10, 0, 8'h20, 0, 8'hA5, 1'b0);
    midCycle(); checkOutput("t2WrReady", 32'(req_ready), 32'h2);
    nextCycle(); applyStimulus(2'b10, 2'b00, 0, 8'h20, 0, 0, 1'b0);
    midCycle(); checkOutput("t2RdReady", 32'(req_ready), 32'h2);
    checkOutput("t2MemWr", 32'(mem_wr_en), 1); checkOutput("t2MemWdata", 32'(mem_wdata), 32'hA5);
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    midCycle();
    nextCycle(); midCycle();
    checkOutput("t2RspValid", 32'(rsp_valid), 32'h2); checkOutput("t2RspData", 32'(rsp_rdata), 32'hA5);

    // Continuous contention alternates grants and yields gap-free responses.
    for (int k = 0; k < 6; k++) begin
      nextCycle(); applyStimulus(2'b11, 2'b00, 8'h10, 8'h20, 0, 0, 1'b0);
      midCycle();
      checkOutput("t3Grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 2) checkOutput("t3Rsp", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    midCycle(); checkOutput("t3TailRsp0", 32'(rsp_valid), 32'h1); checkOutput("t3TailData0", 32'(rsp_rdata), 32'hFF);
    nextCycle(); midCycle();
    checkOutput("t3TailRsp1", 32'(rsp_valid), 32'h2); checkOutput("t3TailData1", 32'(rsp_rdata), 32'hA5);

    // Clear sweep while requester 0 keeps asking.
    nextCycle(); applyStimulus(2'b01, 2'b01, 8'h05, 0, 8'h3C, 0, 1'b0);
    midCycle(); checkOutput("t4WrReady", 32'(req_ready), 32'h1);
    nextCycle(); applyStimulus(2'b01, 2'b00, 8'h05, 0, 0, 0, 1'b1);
    midCycle(); checkOutput("t4StartReady", 32'(req_ready), 0);
    doneBefore = doneCount;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      nextCycle(); applyStimulus(2'b01, 2'b00, 8'h05, 0, 0, 0, 1'b0);
      midCycle();
      if (req_ready !== 2'b00 || busy !== 1'b1) bad++;
    end
    checkOutput("t4ClearWindow", 32'(bad), 0);
    nextCycle(); midCycle();
    checkOutput("t4Done", 32'(clear_done), 1); checkOutput("t4BusyLow", 32'(busy), 0);
    checkOutput("t4FirstGrant", 32'(req_ready), 32'h1); checkOutput("t4LastAddr", 32'(mem_addr), 32'hFF);
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    midCycle();
    nextCycle(); midCycle();
    checkOutput("t4RspValid", 32'(rsp_valid), 32'h1); checkOutput("t4RspData", 32'(rsp_rdata), 32'h00);
    checkOutput("t4DoneOnce", 32'(doneCount - doneBefore), 1);

    // A read accepted just before the clear still answers with pre-clear data.
    nextCycle(); applyStimulus(2'b10, 2'b10, 0, 8'h30, 0, 8'h5A, 1'b0);
    midCycle(); checkOutput("t5WrReady", 32'(req_ready), 32'h2);
    nextCycle(); applyStimulus(2'b10, 2'b00, 0, 8'h30, 0, 0, 1'b0);
    midCycle(); checkOutput("t5RdReady", 32'(req_ready), 32'h2);
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b1);
    midCycle();
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    midCycle();
    checkOutput("t5RspValid", 32'(rsp_valid), 32'h2); checkOutput("t5RspData", 32'(rsp_rdata), 32'h5A);
    checkOutput("t5Busy", 32'(busy), 1);
    hit = 1'b0;
    for (int k = 0; k < DEPTH + 20 && !hit; k++) begin
      nextCycle(); midCycle();
      if (clear_done === 1'b1) hit = 1'b1;
    end
    checkOutput("t5DoneSeen", 32'(hit), 1);

    // Reset in the middle of a sweep aborts it cleanly.
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b1);
    midCycle();
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      nextCycle(); applyStimulus(2'b01, 2'b00, 8'h50, 0, 0, 0, 1'b0);
      midCycle();
      if (mem_wr_en === 1'b1 && mem_addr === 8'h3F) hit = 1'b1;
    end
    checkOutput("t6ReachedAddr", 32'(hit), 1);
    doneBefore = doneCount;
    nextCycle(); reset = 1'b1;
    midCycle(); checkOutput("t6ReadyInReset", 32'(req_ready), 0); checkOutput("t6Addr40", 32'(mem_addr), 32'h40);
    nextCycle(); reset = 1'b0;
    midCycle();
    checkOutput("t6Busy", 32'(busy), 0); checkOutput("t6Done", 32'(clear_done), 0);
    checkOutput("t6MemWr", 32'(mem_wr_en), 0); checkOutput("t6MemRd", 32'(mem_rd_en), 0);
    checkOutput("t6Rsp", 32'(rsp_valid), 0); checkOutput("t6Grant", 32'(req_ready), 32'h1);
    nextCycle(); applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    repeat (5) nextCycle();
    midCycle(); checkOutput("t6NoDone", 32'(doneCount - doneBefore), 0);

    // Random traffic on a narrow address window, with rare clears and resets.
    for (int k = 0; k < 1500; k++) begin
      nextCycle();
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(NR'($urandom), NR'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 299) == 0));
    end
    nextCycle(); reset = 1'b0; applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    repeat (3) nextCycle();
    midCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish before 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
